fifo_rd_ctrl: RTL and testbench

Read-side sequencer for the dual-clock FIFO macro, running entirely in the FIFO read-clock domain. It generates the macro's required reset pulse and post-reset quiet period. It then drains the FIFO into a 2-entry output buffer and presents the data as a valid/ready stream. It absorbs the macro's one-cycle read latency so that downstream logic sees a plain handshake at full throughput.

---
 rtl/fifo_rd_ctrl_if.sv | 31 +++
 rtl/fifo_rd_ctrl.sv | 148 ++++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if
// Groups the FIFO-macro side and the output-stream side of the read sequencer.
//   fifo_reset      : reset pulse to the FIFO macro (active-high)
//   fifo_empty      : FIFO EMPTY flag
//   fifo_read_req   : FIFO read enable
//   fifo_read_data  : FIFO data-out, valid one cycle after fifo_read_req
//   out_valid/out_ready/out_data : valid/ready output stream
//   busy            : high while the reset sequence is in progress
// master = the sequencer itself, slave = the FIFO macro plus the consumer.
interface fifo_rd_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             fifo_reset;
  logic             fifo_empty;
  logic             fifo_read_req;
  logic [WIDTH-1:0] fifo_read_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output fifo_reset, fifo_read_req, out_valid, out_data, busy,
    input  fifo_empty, fifo_read_data, out_ready
  );

  modport slave (
    input  fifo_reset, fifo_read_req, out_valid, out_data, busy,
    output fifo_empty, fifo_read_data, out_ready
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl
// Read-side sequencer for the dual-clock FIFO macro (read-clock domain only).
// After reset it holds the macro in reset for RST_CYCLES cycles, idles for
// RST_WAIT cycles, then drains the FIFO into a 2-entry buffer and presents it
// as a valid/ready stream, hiding the macro's one-cycle read latency.
// Ports:
//   clk   : FIFO read clock
//   reset : synchronous, active-high
//   bus   : fifo_rd_ctrl_if.master (FIFO macro side + output stream + busy)
module fifo_rd_ctrl #(
  parameter int WIDTH      = 8,
  parameter int RST_CYCLES = 5,
  parameter int RST_WAIT   = 4
) (
  input  logic           clk,
  input  logic           reset,
  fifo_rd_ctrl_if.master bus
);

  localparam int CNT_MAX = (RST_CYCLES > RST_WAIT) ? RST_CYCLES : RST_WAIT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RST_WAIT - 1);

  typedef enum logic [1:0] {
    ST_RST_HOLD,
    ST_RST_WAIT,
    ST_RUN
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;

  logic             fifo_reset_q;
  logic             busy_q;
  logic             fifo_reset_d;
  logic             busy_d;
  logic             read_req;

  logic [1:0]       occ;
  logic [1:0]       occ_next;
  logic             inflight;
  logic             valid_q;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             pop;
  logic [2:0]       level_after_pop;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RST_HOLD;
    end else begin
      state <= next_state;
    end
  end

  // Phase counter: restarts on every state change and freezes in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (next_state != state) begin
      cnt <= '0;
    end else if (state != ST_RUN) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_RST_HOLD: if (cnt == HOLD_LAST) next_state = ST_RST_WAIT;
      ST_RST_WAIT: if (cnt == WAIT_LAST) next_state = ST_RUN;
      ST_RUN:      next_state = ST_RUN;
      default:     next_state = ST_RST_HOLD;
    endcase
  end

  // Output logic. fifo_reset/busy are computed from next_state so that the
  // registered copies line up exactly with the state they describe. The read
  // request counts the words already owed to the buffer (occ + inflight) net
  // of this cycle's pop; 3-bit math keeps the subtraction from wrapping.
  always_comb begin
    fifo_reset_d    = (next_state == ST_RST_HOLD);
    busy_d          = (next_state != ST_RUN);
    level_after_pop = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    read_req        = (state == ST_RUN) && !bus.fifo_empty && (level_after_pop < 3'd2);
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_reset_q <= 1'b1;
      busy_q       <= 1'b1;
    end else begin
      fifo_reset_q <= fifo_reset_d;
      busy_q       <= busy_d;
    end
  end

  assign pop      = valid_q & bus.out_ready;
  assign occ_next = occ + {1'b0, inflight} - {1'b0, pop};

  // Two-entry output buffer: head is presented directly, tail queues behind
  // it. A capture always has room because the issue rule never owes more
  // than two words; when capture and pop coincide the head advances and the
  // new word lands behind it.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      valid_q  <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= read_req;
      occ      <= occ_next;
      valid_q  <= (occ_next != 2'd0);
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) head <= bus.fifo_read_data;
          else             tail <= bus.fifo_read_data;
        end
        2'b01: begin
          if (occ == 2'd2) head <= tail;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= bus.fifo_read_data;
          end else begin
            head <= tail;
            tail <= bus.fifo_read_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_reset    = fifo_reset_q;
  assign bus.busy          = busy_q;
  assign bus.fifo_read_req = read_req;
  assign bus.out_valid     = valid_q;
  assign bus.out_data      = head;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl
// Bench for fifo_rd_ctrl: models the FIFO macro (queue with one-cycle read
// latency) and a consumer. Every word written into the FIFO model is also
// pushed onto an expected queue; a negedge monitor pops it whenever the DUT
// hands over a word and compares. Directed phases cover the reset sequence,
// single word, streaming, backpressure, random traffic and reset mid-stream.
module tb_fifo_rd_ctrl;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  fifo_rd_ctrl_if #(.WIDTH(WIDTH)) bus ();

  fifo_rd_ctrl #(
    .WIDTH     (WIDTH),
    .RST_CYCLES(5),
    .RST_WAIT  (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] fifo_model[$];
  logic [WIDTH-1:0] exp_q[$];

  logic             req_last  = 1'b0;
  int               pops_total = 0;
  int               issued    = 0;
  int               popped    = 0;
  logic             hold_prev = 1'b0;
  logic [WIDTH-1:0] data_prev = '0;

  // One comparison: counts it, and reports it if the values differ.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, want);
    end
  endtask

  // Advance one clock cycle through the FIFO macro model: a read requested in
  // this cycle pops the model and shows the word on fifo_read_data just after
  // the edge; otherwise the data port carries junk.
  task automatic applyStimulus();
    @(negedge clk);
    req_last = bus.fifo_read_req && !reset;
    @(posedge clk);
    #1;
    if (req_last) begin
      checkOutput("read_has_data", 32'(fifo_model.size() != 0), 32'd1);
      if (fifo_model.size() != 0) bus.fifo_read_data = fifo_model.pop_front();
    end else begin
      bus.fifo_read_data = WIDTH'($urandom);
    end
    if (bus.fifo_reset === 1'b1) fifo_model.delete();
    bus.fifo_empty = (fifo_model.size() == 0);
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    fifo_model.push_back(w);
    exp_q.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    exp_q.delete();
    fifo_model.delete();
    bus.fifo_empty = 1'b1;
    applyStimulus();
    reset = 1'b0;
  endtask

  // Watches out_valid for a number of cycles and reports how many were high
  // and where the first and last ones fell.
  task automatic measure_run(input int cycles, output int nvalid, output int first, output int last);
    nvalid = 0;
    first  = -1;
    last   = -1;
    for (int c = 0; c < cycles; c++) begin
      if (bus.out_valid) begin
        nvalid++;
        if (first < 0) first = c;
        last = c;
      end
      applyStimulus();
    end
  endtask

  // Monitor: scoreboard pops, hold-stable check, no reads while empty, and
  // at most two words owed to the buffer at any time.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        issued    = 0;
        popped    = 0;
        hold_prev = 1'b0;
      end else begin
        checkOutput("outstanding_le2", 32'((issued - popped) <= 2), 32'd1);
        if (bus.fifo_read_req) checkOutput("read_while_empty", 32'(bus.fifo_empty), 32'd0);
        if (hold_prev) begin
          checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
          checkOutput("hold_data", 32'(bus.out_data), 32'(data_prev));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL sb_unexpected: got %0h required no word", bus.out_data);
          end else begin
            checkOutput("sb_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
          end
          pops_total++;
          popped++;
        end
        if (bus.fifo_read_req) issued++;
        hold_prev = bus.out_valid && !bus.out_ready;
        data_prev = bus.out_data;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nvalid, first, last, nreq, written, start, cycles, n;

    bus.out_ready      = 1'b0;
    bus.fifo_empty     = 1'b1;
    bus.fifo_read_data = '0;
    reset              = 1'b1;
    repeat (3) applyStimulus();
    reset         = 1'b0;
    bus.out_ready = 1'b1;

    // Reset sequence followed by a single word written once fifo_reset drops.
    for (int k = 0; k < 15; k++) begin
      if (k == 0) checkOutput("reset_out_data", 32'(bus.out_data), 32'd0);
      checkOutput("seq_fifo_reset", 32'(bus.fifo_reset), 32'(k < 5));
      checkOutput("seq_busy", 32'(bus.busy), 32'(k < 9));
      checkOutput("seq_out_valid", 32'(bus.out_valid), 32'(k == 11));
      if (k == 11) checkOutput("single_data", 32'(bus.out_data), 32'h0A5);
      if (k == 5) push_word(8'hA5);
      applyStimulus();
      checkOutput("seq_read_req", 32'(req_last), 32'(k == 9));
    end

    // Streaming 16 words at full throughput.
    repeat (3) applyStimulus();
    for (int i = 0; i < 16; i++) push_word(WIDTH'(i));
    measure_run(40, nvalid, first, last);
    checkOutput("stream_count", 32'(nvalid), 32'd16);
    checkOutput("stream_span", 32'(last - first + 1), 32'd16);
    checkOutput("stream_latency", 32'(first), 32'd2);

    // Backpressure: only two words may be pulled while the consumer stalls.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(WIDTH'(i));
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus();
      nreq += int'(req_last);
    end
    checkOutput("bp_reads", 32'(nreq), 32'd2);
    checkOutput("bp_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("bp_data", 32'(bus.out_data), 32'd0);
    bus.out_ready = 1'b1;
    measure_run(20, nvalid, first, last);
    checkOutput("bp_count", 32'(nvalid), 32'd8);
    checkOutput("bp_span", 32'(last - first + 1), 32'd8);
    checkOutput("bp_first", 32'(first), 32'd0);

    // Random consumer and random refill, 1000 words.
    written = 0;
    cycles  = 0;
    start   = pops_total;
    while ((pops_total - start) < 1000 && cycles < 8000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (written < 1000 && $urandom_range(0, 99) < 60) begin
        push_word(WIDTH'($urandom));
        written++;
      end
      applyStimulus();
      cycles++;
    end
    checkOutput("random_delivered", 32'(pops_total - start), 32'd1000);

    // Reset with a full buffer: buffered and queued words are discarded.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(WIDTH'(8'h50 + i));
    repeat (6) applyStimulus();
    checkOutput("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    reset_dut();
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_fifo_reset", 32'(bus.fifo_reset), 32'd1);
    checkOutput("rst_busy", 32'(bus.busy), 32'd1);
    n = 0;
    while (bus.busy && n < 30) begin
      applyStimulus();
      n++;
    end
    checkOutput("rst_busy_fell", 32'(bus.busy), 32'd0);
    checkOutput("rst_seq_len", 32'(n), 32'd9);
    start         = pops_total;
    bus.out_ready = 1'b1;
    push_word(8'hC0);
    push_word(8'hC1);
    push_word(8'hC2);
    repeat (10) applyStimulus();
    checkOutput("rst_new_words", 32'(pops_total - start), 32'd3);

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
